// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer, flush,
// exception-clear bubble injection and exception side-band merge.
module pipe_stage_elastic #(
    parameter int PAYLOAD_W = 64,
    parameter int PC_W      = 32,
    parameter int EXC_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 exc_clr,
    input  logic [PC_W-1:0]      epc,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [31:0]          in_instr,
    input  logic                 in_bd,
    input  logic                 in_exc_get,
    input  logic [EXC_W-1:0]     in_exc_code,
    input  logic                 loc_exc_get,
    input  logic [EXC_W-1:0]     loc_exc_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bubble,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [PC_W-1:0]      out_pc,
    output logic [31:0]          out_instr,
    output logic                 out_bd,
    output logic                 out_exc_get,
    output logic [EXC_W-1:0]     out_exc_code,
    output logic [1:0]           occupancy
);

    typedef struct packed {
        logic                 valid;
        logic                 bubble;
        logic [PAYLOAD_W-1:0] payload;
        logic [PC_W-1:0]      pc;
        logic [31:0]          instr;
        logic                 bd;
        logic                 exc_get;
        logic [EXC_W-1:0]     exc_code;
    } ent_t;

    ent_t       r_h;
    ent_t       r_s;
    ent_t       w_h_n;
    ent_t       w_s_n;
    ent_t       w_in_ent;
    ent_t       w_bub_ent;
    logic       r_in_ready;
    logic [1:0] r_occ;
    logic       w_in_fire;
    logic       w_out_fire;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_h.valid & out_ready;

    // The older exception always wins over one raised locally.
    always_comb begin
        w_in_ent          = '0;
        w_in_ent.valid    = 1'b1;
        w_in_ent.payload  = in_payload;
        w_in_ent.pc       = in_pc;
        w_in_ent.instr    = in_instr;
        w_in_ent.bd       = in_bd;
        w_in_ent.exc_get  = in_exc_get | loc_exc_get;
        if (in_exc_get)
            w_in_ent.exc_code = in_exc_code;
        else if (loc_exc_get)
            w_in_ent.exc_code = loc_exc_code;
        else
            w_in_ent.exc_code = '0;
    end

    always_comb begin
        w_bub_ent        = '0;
        w_bub_ent.valid  = 1'b1;
        w_bub_ent.bubble = 1'b1;
        w_bub_ent.pc     = epc;
    end

    // Invalid slots are zeroed so idle outputs read as 0.
    always_comb begin
        w_h_n = r_h;
        w_s_n = r_s;
        if (exc_clr) begin
            w_h_n = w_bub_ent;
            w_s_n = '0;
        end else if (flush) begin
            w_h_n = '0;
            w_s_n = '0;
        end else if (!r_h.valid || w_out_fire) begin
            if (r_s.valid) begin
                w_h_n = r_s;
                w_s_n = w_in_fire ? w_in_ent : '0;
            end else begin
                w_h_n = w_in_fire ? w_in_ent : '0;
            end
        end else if (w_in_fire) begin
            w_s_n = w_in_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h        <= '0;
            r_s        <= '0;
            r_in_ready <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            r_h        <= w_h_n;
            r_s        <= w_s_n;
            r_in_ready <= ~w_s_n.valid;
            r_occ      <= {1'b0, w_h_n.valid} + {1'b0, w_s_n.valid};
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_h.valid;
    assign out_bubble   = r_h.bubble;
    assign out_payload  = r_h.payload;
    assign out_pc       = r_h.pc;
    assign out_instr    = r_h.instr;
    assign out_bd       = r_h.bd;
    assign out_exc_get  = r_h.exc_get;
    assign out_exc_code = r_h.exc_code;
    assign occupancy    = r_occ;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Testbench for pipe_stage_elastic: scenario tasks plus a
// queue scoreboard that checks every output transfer in order.
module tb_pipe_stage_elastic;

    localparam int PW = 64;
    localparam int CW = 32;
    localparam int EW = 5;

    typedef struct packed {
        logic          bubble;
        logic [PW-1:0] payload;
        logic [CW-1:0] pc;
        logic [31:0]   instr;
        logic          bd;
        logic          exc_get;
        logic [EW-1:0] exc_code;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          exc_clr = 1'b0;
    logic [CW-1:0] epc = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_payload = '0;
    logic [CW-1:0] in_pc = '0;
    logic [31:0]   in_instr = '0;
    logic          in_bd = 1'b0;
    logic          in_exc_get = 1'b0;
    logic [EW-1:0] in_exc_code = '0;
    logic          loc_exc_get = 1'b0;
    logic [EW-1:0] loc_exc_code = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_bubble;
    logic [PW-1:0] out_payload;
    logic [CW-1:0] out_pc;
    logic [31:0]   out_instr;
    logic          out_bd;
    logic          out_exc_get;
    logic [EW-1:0] out_exc_code;
    logic [1:0]    occupancy;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    pipe_stage_elastic #(
        .PAYLOAD_W(PW),
        .PC_W(CW),
        .EXC_W(EW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .exc_clr(exc_clr),
        .epc(epc),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_payload(in_payload),
        .in_pc(in_pc),
        .in_instr(in_instr),
        .in_bd(in_bd),
        .in_exc_get(in_exc_get),
        .in_exc_code(in_exc_code),
        .loc_exc_get(loc_exc_get),
        .loc_exc_code(loc_exc_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bubble(out_bubble),
        .out_payload(out_payload),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .out_bd(out_bd),
        .out_exc_get(out_exc_get),
        .out_exc_code(out_exc_code),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic scoreboard();
        exp_t e;
        exp_t got;
        if (reset) return;
        if (out_valid && out_ready) begin
            got = '{out_bubble, out_payload, out_pc, out_instr,
                    out_bd, out_exc_get, out_exc_code};
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: got %h required nothing", got);
            end else begin
                e = sb_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL sb_entry: got %h required %h", got, e);
                end
            end
        end
        if (exc_clr) begin
            sb_q.delete();
            e = '0;
            e.bubble = 1'b1;
            e.pc = epc;
            sb_q.push_back(e);
        end else if (flush) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            e = '0;
            e.payload = in_payload;
            e.pc = in_pc;
            e.instr = in_instr;
            e.bd = in_bd;
            e.exc_get = in_exc_get | loc_exc_get;
            e.exc_code = in_exc_get ? in_exc_code :
                         (loc_exc_get ? loc_exc_code : '0);
            sb_q.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        scoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CW-1:0] pc);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_payload = {32'hA5A5_0000, pc} ^ 64'h0F0F_1234_0000_0000;
        in_instr   = 32'h2000_0000 | pc;
        in_bd      = pc[2];
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        in_exc_get   = 1'b0;
        in_exc_code  = '0;
        loc_exc_get  = 1'b0;
        loc_exc_code = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL rst_hold: got v=%b rdy=%b occ=%0d required 0 0 0",
                     out_valid, in_ready, occupancy);
        end
        n_cmp++;
        if (out_pc !== '0 || out_payload !== '0 || out_bubble !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fields: got pc=%h pl=%h bub=%b required 0",
                     out_pc, out_payload, out_bubble);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || occupancy !== 2'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_release: got rdy=%b occ=%0d v=%b required 1 0 0",
                     in_ready, occupancy, out_valid);
        end
    endtask

    task automatic test_single();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_pc      = 32'h3000;
        in_payload = 64'h0123_4567_89AB_CDEF;
        in_instr   = 32'h8C22_0010;
        in_bd      = 1'b1;
        step();
        idle_in();
        n_cmp++;
        if (out_valid !== 1'b1 || out_payload !== 64'h0123_4567_89AB_CDEF ||
            out_pc !== 32'h3000 || out_instr !== 32'h8C22_0010 || out_bd !== 1'b1) begin
            n_err++;
            $display("FAIL single_out: got v=%b pl=%h pc=%h ins=%h bd=%b required 1 0123456789abcdef 3000 8c220010 1",
                     out_valid, out_payload, out_pc, out_instr, out_bd);
        end
        n_cmp++;
        if (occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL single_occ1: got %0d required 1", occupancy);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL single_drain: got v=%b occ=%0d required 0 0",
                     out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(32'h3000);
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL bp_c1: got rdy=%b occ=%0d required 1 1", in_ready, occupancy);
        end
        drive(32'h3004);
        step();
        drive(32'h3008);
        n_cmp++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
            n_err++;
            $display("FAIL bp_c2: got rdy=%b occ=%0d required 0 2", in_ready, occupancy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_pc !== 32'h3000 || out_valid !== 1'b1 ||
                in_ready !== 1'b0 || occupancy !== 2'd2) begin
                n_err++;
                $display("FAIL bp_hold: got pc=%h v=%b rdy=%b occ=%0d required 3000 1 0 2",
                         out_pc, out_valid, in_ready, occupancy);
            end
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_pc !== 32'h3004 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL bp_r1: got pc=%h rdy=%b occ=%0d required 3004 1 1",
                     out_pc, in_ready, occupancy);
        end
        step();
        idle_in();
        n_cmp++;
        if (out_pc !== 32'h3008 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_r2: got pc=%h v=%b required 3008 1", out_pc, out_valid);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL bp_drain: got v=%b occ=%0d required 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_stream();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(32'h6000 + 32'(4 * i));
            step();
            if (in_ready !== 1'b1 || occupancy !== 2'd1 || out_valid !== 1'b1 ||
                out_pc !== 32'h6000 + 32'(4 * i))
                bad++;
        end
        idle_in();
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stream: got %0d bad cycles required 0", bad);
        end
        step();
    endtask

    task automatic test_exc_merge();
        out_ready = 1'b1;
        drive(32'h7000);
        loc_exc_get  = 1'b1;
        loc_exc_code = 5'd12;
        step();
        n_cmp++;
        if (out_exc_get !== 1'b1 || out_exc_code !== 5'd12) begin
            n_err++;
            $display("FAIL exc_loc: got g=%b c=%0d required 1 12", out_exc_get, out_exc_code);
        end
        drive(32'h7004);
        in_exc_get  = 1'b1;
        in_exc_code = 5'd4;
        step();
        n_cmp++;
        if (out_exc_get !== 1'b1 || out_exc_code !== 5'd4) begin
            n_err++;
            $display("FAIL exc_old: got g=%b c=%0d required 1 4", out_exc_get, out_exc_code);
        end
        drive(32'h7008);
        in_exc_get  = 1'b0;
        in_exc_code = 5'd9;
        loc_exc_get = 1'b0;
        step();
        idle_in();
        n_cmp++;
        if (out_exc_get !== 1'b0 || out_exc_code !== 5'd0) begin
            n_err++;
            $display("FAIL exc_none: got g=%b c=%0d required 0 0", out_exc_get, out_exc_code);
        end
        step();
    endtask

    task automatic check_bubble(input string nm);
        n_cmp++;
        if (out_valid !== 1'b1 || out_bubble !== 1'b1 || out_pc !== 32'h4180 ||
            out_instr !== '0 || out_payload !== '0 || occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL %s: got v=%b bub=%b pc=%h ins=%h pl=%h occ=%0d required 1 1 4180 0 0 1",
                     nm, out_valid, out_bubble, out_pc, out_instr, out_payload, occupancy);
        end
    endtask

    task automatic test_exc_clr();
        out_ready = 1'b0;
        drive(32'h3000);
        step();
        drive(32'h3004);
        step();
        drive(32'h5000);
        exc_clr = 1'b1;
        epc = 32'h4180;
        step();
        exc_clr = 1'b0;
        idle_in();
        check_bubble("exc_clr_full");
        out_ready = 1'b1;
        drive(32'h5100);
        exc_clr = 1'b1;
        step();
        exc_clr = 1'b0;
        idle_in();
        check_bubble("exc_clr_fire");
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL exc_clr_drain: got v=%b occ=%0d rdy=%b required 0 0 1",
                     out_valid, occupancy, in_ready);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'h3000);
        step();
        drive(32'h3004);
        flush = 1'b1;
        exc_clr = 1'b1;
        epc = 32'h4180;
        step();
        flush = 1'b0;
        exc_clr = 1'b0;
        idle_in();
        check_bubble("flush_both");
        drive(32'h3008);
        step();
        drive(32'h300C);
        step();
        n_cmp++;
        if (occupancy !== 2'd2) begin
            n_err++;
            $display("FAIL flush_fill: got occ=%0d required 2", occupancy);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 ||
            in_ready !== 1'b1 || out_bubble !== 1'b0) begin
            n_err++;
            $display("FAIL flush_only: got v=%b occ=%0d rdy=%b bub=%b required 0 0 1 0",
                     out_valid, occupancy, in_ready, out_bubble);
        end
        out_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_exc_merge();
        test_exc_clr();
        test_flush();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
